// File: rtl/trap_controller.sv
// -----------------------------------------------------------------------------
// trap_controller
//   Machine-mode trap sequencer. Registers synchronous traps (illegal, ecall)
//   from decode and NUM_IRQ level-triggered interrupt lines. Holds the machine
//   trap CSRs and walks trap entry (IDLE -> SAVE -> JUMP) and mret.
//
// Ports
//   clk, rst     clock, asynchronous active-high reset
//   instr_valid  decode holds a valid, retiring instruction
//   int_cause    0 none, 1 illegal, 2 ecall, 3 ignored
//   mret         decode flags mret
//   pc           PC of the decode-stage instruction
//   irq          external interrupt lines (level), index 0 highest priority
//   csr_we/csr_addr/csr_wdata   CSR write port; csr_rdata combinational read
//   stall        freeze fetch/decode
//   kill         squash the decode-stage instruction
//   redirect     one-cycle strobe: load PC from target
//   target       redirect destination
// -----------------------------------------------------------------------------
module trap_controller #(
    parameter int              XLEN        = 32,
    parameter int              NUM_IRQ     = 4,
    parameter logic [XLEN-1:0] MTVEC_RESET = XLEN'(32'h0000_0008)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               instr_valid,
    input  logic [1:0]         int_cause,
    input  logic               mret,
    input  logic [XLEN-1:0]    pc,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               csr_we,
    input  logic [11:0]        csr_addr,
    input  logic [XLEN-1:0]    csr_wdata,
    output logic [XLEN-1:0]    csr_rdata,
    output logic               stall,
    output logic               kill,
    output logic               redirect,
    output logic [XLEN-1:0]    target
);

    localparam int IDXW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    localparam logic [11:0] A_MSTATUS = 12'h300;
    localparam logic [11:0] A_MIE     = 12'h304;
    localparam logic [11:0] A_MTVEC   = 12'h305;
    localparam logic [11:0] A_MEPC    = 12'h341;
    localparam logic [11:0] A_MCAUSE  = 12'h342;
    localparam logic [11:0] A_MIP     = 12'h344;

    typedef enum logic [1:0] {IDLE, SAVE, JUMP} state_t;

    state_t              state, state_next;
    logic                st_mie, st_mpie;
    logic [NUM_IRQ-1:0]  mie_r, pending, clr_mask;
    logic [XLEN-1:0]     mtvec, mepc, mcause;

    // Trap context captured at entry, consumed in SAVE/JUMP.
    logic [XLEN-1:0]     lat_pc, lat_code;
    logic                lat_irq;
    logic [IDXW-1:0]     lat_idx;

    logic                sync_exc, irq_any, take_sync, take_irq, take_mret;
    logic [NUM_IRQ-1:0]  irq_hit;
    logic [IDXW-1:0]     irq_idx;
    logic [XLEN-1:0]     trap_code, trap_base, trap_target;

    // ---------------- trap selection ----------------
    assign sync_exc = (int_cause == 2'd1) || (int_cause == 2'd2);
    assign irq_hit  = pending & mie_r & {NUM_IRQ{st_mie}};
    assign irq_any  = |irq_hit;

    // Priority encoder: scanning downward leaves the lowest set index.
    always_comb begin
        irq_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (irq_hit[i]) irq_idx = IDXW'(i);
        end
    end

    assign take_sync = (state == IDLE) && instr_valid && sync_exc;
    assign take_irq  = (state == IDLE) && instr_valid && !sync_exc && irq_any;
    assign take_mret = (state == IDLE) && instr_valid && !sync_exc && !irq_any && mret;

    always_comb begin
        if (take_sync)
            trap_code = (int_cause == 2'd1) ? XLEN'(2) : XLEN'(11);
        else
            trap_code = {1'b1, (XLEN-1)'(16) + (XLEN-1)'(irq_idx)};
    end

    assign trap_base   = mtvec & ~XLEN'(3);
    assign trap_target = (mtvec[1:0] == 2'b01 && lat_irq)
                       ? trap_base + ((XLEN'(16) + XLEN'(lat_idx)) << 2)
                       : trap_base;

    always_comb begin
        clr_mask = '0;
        if (state == SAVE && lat_irq) clr_mask[lat_idx] = 1'b1;
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        state_next = state;
        stall      = 1'b0;
        kill       = 1'b0;
        redirect   = 1'b0;
        target     = '0;
        case (state)
            IDLE: begin
                if (take_sync || take_irq) begin
                    kill       = 1'b1;
                    stall      = 1'b1;
                    state_next = SAVE;
                end else if (take_mret) begin
                    kill     = 1'b1;
                    redirect = 1'b1;
                    target   = mepc;
                end
            end
            SAVE: begin
                stall      = 1'b1;
                state_next = JUMP;
            end
            JUMP: begin
                stall      = 1'b1;
                redirect   = 1'b1;
                target     = trap_target;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // Outputs are forced quiet while reset is held, whatever decode drives.
        if (rst) begin
            stall    = 1'b0;
            kill     = 1'b0;
            redirect = 1'b0;
            target   = '0;
        end
    end

    // ---------------- trap context latch ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_pc   <= '0;
            lat_code <= '0;
            lat_irq  <= 1'b0;
            lat_idx  <= '0;
        end else if (take_sync || take_irq) begin
            lat_pc   <= pc;
            lat_code <= trap_code;
            lat_irq  <= take_irq;
            lat_idx  <= irq_idx;
        end
    end

    // ---------------- CSRs ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_mie  <= 1'b0;
            st_mpie <= 1'b0;
            mie_r   <= '0;
            mtvec   <= MTVEC_RESET;
            mepc    <= '0;
            mcause  <= '0;
            pending <= '0;
        end else begin
            // A still-asserted line re-arms its pending bit even as it clears.
            pending <= (pending & ~clr_mask) | irq;

            if (csr_we) begin
                case (csr_addr)
                    A_MSTATUS: begin
                        st_mie  <= csr_wdata[3];
                        st_mpie <= csr_wdata[7];
                    end
                    A_MIE:    mie_r  <= csr_wdata[NUM_IRQ-1:0];
                    A_MTVEC:  mtvec  <= csr_wdata;
                    A_MEPC:   mepc   <= csr_wdata & ~XLEN'(3);
                    A_MCAUSE: mcause <= csr_wdata;
                    default: ;
                endcase
            end

            // NOTE: these come after the CSR write so, with non-blocking
            // assignment, the later FSM update wins in a colliding cycle.
            if (state == SAVE) begin
                mepc    <= lat_pc & ~XLEN'(3);
                mcause  <= lat_code;
                st_mpie <= st_mie;
                st_mie  <= 1'b0;
            end else if (take_mret) begin
                st_mie  <= st_mpie;
                st_mpie <= 1'b1;
            end
        end
    end

    always_comb begin
        csr_rdata = '0;
        case (csr_addr)
            A_MSTATUS: begin
                csr_rdata[3] = st_mie;
                csr_rdata[7] = st_mpie;
            end
            A_MIE:    csr_rdata = XLEN'(mie_r);
            A_MTVEC:  csr_rdata = mtvec;
            A_MEPC:   csr_rdata = mepc;
            A_MCAUSE: csr_rdata = mcause;
            A_MIP:    csr_rdata = XLEN'(pending);
            default:  csr_rdata = '0;
        endcase
    end

endmodule
